// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Brief    : Two's-complement add/sub resolving CHUNK bits per pipeline stage,
//            with valid/ready backpressure and carry/overflow/zero flags.
// Revision : 1.0
// ============================================================================
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int MSB    = WIDTH - 1;

    // Index 0 holds the captured operands; index k holds the result with k chunks resolved.
    logic [STAGES:0]  vld_q, vld_d;
    logic [STAGES:0]  cry_q, cry_d;
    logic [WIDTH-1:0] acc_q [STAGES+1];
    logic [WIDTH-1:0] acc_d [STAGES+1];
    logic [WIDTH-1:0] opa_q [STAGES];
    logic [WIDTH-1:0] opa_d [STAGES];
    logic [WIDTH-1:0] opb_q [STAGES];
    logic [WIDTH-1:0] opb_d [STAGES];
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             adv;
    logic [CHUNK:0]   part;

    always_comb begin
        adv    = !vld_q[STAGES] || out_ready;
        vld_d  = vld_q;
        cry_d  = cry_q;
        acc_d  = acc_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        part   = '0;
        if (adv) begin
            vld_d[0] = in_valid;
            opa_d[0] = a;
            opb_d[0] = sub ? ~b : b;
            cry_d[0] = sub ? 1'b1 : cin;
            acc_d[0] = '0;
            for (int k = 1; k <= STAGES; k++) begin
                part = {1'b0, opa_q[k-1][(k-1)*CHUNK +: CHUNK]}
                     + {1'b0, opb_q[k-1][(k-1)*CHUNK +: CHUNK]}
                     + {{CHUNK{1'b0}}, cry_q[k-1]};
                vld_d[k] = vld_q[k-1];
                acc_d[k] = acc_q[k-1];
                acc_d[k][(k-1)*CHUNK +: CHUNK] = part[CHUNK-1:0];
                cry_d[k] = part[CHUNK];
            end
            for (int k = 1; k < STAGES; k++) begin
                opa_d[k] = opa_q[k-1];
                opb_d[k] = opb_q[k-1];
            end
            // Same-sign operands producing a result of the other sign.
            ovf_d  = (opa_q[STAGES-1][MSB] == opb_q[STAGES-1][MSB]) &&
                     (acc_d[STAGES][MSB] != opa_q[STAGES-1][MSB]);
            zero_d = ~|acc_d[STAGES];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q  <= '0;
            cry_q  <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int k = 0; k <= STAGES; k++) begin
                acc_q[k] <= '0;
            end
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else begin
            vld_q  <= vld_d;
            cry_q  <= cry_d;
            acc_q  <= acc_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES];
    assign sum       = acc_q[STAGES];
    assign cout      = cry_q[STAGES];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub
// Brief    : Self-checking bench for pipelined_addsub at 32/8, 16/4 and 16/16.
// Revision : 1.0
// ============================================================================
module tb_pipelined_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;

    logic        ir32, ov32, co32, of32, z32;
    logic [31:0] sum32;
    logic        ir16a, ov16a, co16a, of16a, z16a;
    logic [15:0] sum16a;
    logic        ir16b, ov16b, co16b, of16b, z16b;
    logic [15:0] sum16b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipelined_addsub #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready),
        .sum(sum32), .cout(co32), .overflow(of32), .zero(z32)
    );

    pipelined_addsub #(.WIDTH(16), .CHUNK(4)) u16a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16a),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ov16a), .out_ready(out_ready),
        .sum(sum16a), .cout(co16a), .overflow(of16a), .zero(z16a)
    );

    pipelined_addsub #(.WIDTH(16), .CHUNK(16)) u16b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16b),
        .a(a[15:0]), .b(b[15:0]), .cin(cin), .sub(sub), .out_valid(ov16b), .out_ready(out_ready),
        .sum(sum16b), .cout(co16b), .overflow(of16b), .zero(z16b)
    );

    // Reference: {zero, overflow, cout, sum} from plain integer arithmetic on w-bit values.
    function automatic logic [34:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        longint unsigned mask, ux, uy, r;
        longint          sx, sy, sr, lim;
        logic            co, ov;
        mask = (64'd1 << w) - 64'd1;
        ux   = 64'(x) & mask;
        uy   = 64'(y) & mask;
        lim  = longint'(64'd1 << (w - 1));
        sx   = (ux >= 64'(lim)) ? longint'(ux) - 2 * lim : longint'(ux);
        sy   = (uy >= 64'(lim)) ? longint'(uy) - 2 * lim : longint'(uy);
        if (s) begin
            r  = (ux - uy) & mask;
            co = (ux >= uy);
            sr = sx - sy;
        end else begin
            r  = ux + uy + 64'(ci);
            co = (r > mask);
            r  = r & mask;
            sr = sx + sy + longint'(ci);
        end
        ov = (sr >= lim) || (sr < -lim);
        return {(r == 64'd0), ov, co, r[31:0]};
    endfunction

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (ov32 !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", ov32); end
        n_checks++;
        if (ir32 !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", ir32); end
        n_checks++;
        if (sum32 !== 32'h0) begin n_errors++; $display("FAIL reset_sum: got %h expected 0", sum32); end
        n_checks++;
        if ({co32, of32, z32} !== 3'b000) begin
            n_errors++; $display("FAIL reset_flags: got %b expected 000", {co32, of32, z32});
        end
        n_checks++;
        if ({ov16a, ov16b} !== 2'b00) begin
            n_errors++; $display("FAIL reset_out_valid16: got %b expected 00", {ov16a, ov16b});
        end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_flags();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [1:0]  vcs [6];
        logic [31:0] es [6];
        logic [2:0]  ef [6];
        int          lat;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1; vcs[0] = 2'b00; es[0] = 32'h0000_0000; ef[0] = 3'b101;
        va[1] = 32'h7FFF_FFFF; vb[1] = 32'h1; vcs[1] = 2'b00; es[1] = 32'h8000_0000; ef[1] = 3'b010;
        va[2] = 32'h3;         vb[2] = 32'h4; vcs[2] = 2'b10; es[2] = 32'h0000_0008; ef[2] = 3'b000;
        va[3] = 32'h5;         vb[3] = 32'h7; vcs[3] = 2'b01; es[3] = 32'hFFFF_FFFE; ef[3] = 3'b000;
        va[4] = 32'h8000_0000; vb[4] = 32'h1; vcs[4] = 2'b01; es[4] = 32'h7FFF_FFFF; ef[4] = 3'b110;
        va[5] = 32'h5;         vb[5] = 32'h7; vcs[5] = 2'b11; es[5] = 32'hFFFF_FFFE; ef[5] = 3'b000;
        for (int i = 0; i < 6; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            a = va[i]; b = vb[i]; cin = vcs[i][1]; sub = vcs[i][0];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            lat = 0;
            while (!ov32 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            n_checks++;
            if (lat != 4) begin n_errors++; $display("FAIL flags_latency[%0d]: got %0d expected 4", i, lat); end
            n_checks++;
            if (sum32 !== es[i]) begin n_errors++; $display("FAIL flags_sum[%0d]: got %h expected %h", i, sum32, es[i]); end
            n_checks++;
            if ({co32, of32, z32} !== ef[i]) begin
                n_errors++; $display("FAIL flags_cout_ovf_zero[%0d]: got %b expected %b", i, {co32, of32, z32}, ef[i]);
            end
        end
        idle(2);
    endtask

    task automatic test_back_to_back();
        logic [31:0] got [8];
        logic [31:0] hold;
        int          idx, c, npop;
        idx = 0; c = 0; npop = 0; hold = '0;
        cin = 1'b0; sub = 1'b0;
        while (npop < 8 && c < 40) begin
            in_valid  = (idx < 8);
            a         = 32'(idx);
            b         = 32'(idx * 3);
            out_ready = (c < 5) || (c >= 8);
            @(negedge clk);
            if (c == 5) begin
                n_checks++;
                if (ir32 !== 1'b0) begin n_errors++; $display("FAIL b2b_in_ready_drop: got %b expected 0", ir32); end
                hold = sum32;
            end
            if (c == 6 || c == 7) begin
                n_checks++;
                if (ov32 !== 1'b1 || sum32 !== hold) begin
                    n_errors++; $display("FAIL b2b_stall_hold: got v=%b sum=%h expected v=1 sum=%h", ov32, sum32, hold);
                end
            end
            if (ov32 && out_ready) begin
                got[npop] = sum32;
                npop++;
            end
            if (in_valid && ir32) idx++;
            @(posedge clk);
            #1;
            c++;
        end
        n_checks++;
        if (npop != 8) begin n_errors++; $display("FAIL b2b_count: got %0d expected 8", npop); end
        for (int i = 0; i < npop; i++) begin
            n_checks++;
            if (got[i] !== 32'(4 * i)) begin n_errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, got[i], 32'(4 * i)); end
        end
        idle(6);
    endtask

    task automatic test_reset_flush();
        int lat;
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a = 32'(100 + i);
            b = 32'(i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (ov32 !== 1'b0) begin n_errors++; $display("FAIL flush_no_output[%0d]: got %b expected 0 (sum %h)", i, ov32, sum32); end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1; a = 32'h1; b = 32'h1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!ov32 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        n_checks++;
        if (lat != 4) begin n_errors++; $display("FAIL flush_latency: got %0d expected 4", lat); end
        n_checks++;
        if (sum32 !== 32'h2) begin n_errors++; $display("FAIL flush_sum: got %h expected 2", sum32); end
        idle(6);
    endtask

    task automatic test_width16();
        int          la, lb;
        logic [15:0] sa, sb;
        la = -1; lb = -1; sa = '0; sb = '0;
        out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; a = 32'h0000_0FFF; b = 32'h1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (ov16a && la < 0) begin la = n; sa = sum16a; end
            if (ov16b && lb < 0) begin lb = n; sb = sum16b; end
        end
        n_checks++;
        if (la != 4) begin n_errors++; $display("FAIL w16c4_latency: got %0d expected 4", la); end
        n_checks++;
        if (sa !== 16'h1000) begin n_errors++; $display("FAIL w16c4_sum: got %h expected 1000", sa); end
        n_checks++;
        if (lb != 1) begin n_errors++; $display("FAIL w16c16_latency: got %0d expected 1", lb); end
        n_checks++;
        if (sb !== 16'h1000) begin n_errors++; $display("FAIL w16c16_sum: got %h expected 1000", sb); end
        idle(4);
    endtask

    task automatic test_random();
        logic [34:0] q32 [$];
        logic [34:0] q16a [$];
        logic [34:0] q16b [$];
        logic [34:0] exp;
        int          acc32, acc16a, acc16b, cyc, drain;
        acc32 = 0; acc16a = 0; acc16b = 0; cyc = 0; drain = 0;
        while (drain < 20 && cyc < 60000) begin
            if (acc32 >= 10000 && acc16a >= 10000 && acc16b >= 10000) begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
                drain++;
            end else begin
                in_valid  = ($urandom_range(0, 99) < 80);
                out_ready = ($urandom_range(0, 99) < 75);
                a   = $urandom;
                b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n_checks++;
            if ({ir32, ir16a, ir16b} !== {(!ov32 || out_ready), (!ov16a || out_ready), (!ov16b || out_ready)}) begin
                n_errors++; $display("FAIL rand_in_ready: got %b with out_valid %b out_ready %b",
                                     {ir32, ir16a, ir16b}, {ov32, ov16a, ov16b}, out_ready);
            end
            if (ov32 && out_ready) begin
                n_checks++;
                if (q32.size() == 0) begin
                    n_errors++; $display("FAIL rand32_spurious: got sum %h expected no output", sum32);
                end else begin
                    exp = q32.pop_front();
                    if ({z32, of32, co32, sum32} !== exp) begin
                        n_errors++; $display("FAIL rand32_result: got %h expected %h", {z32, of32, co32, sum32}, exp);
                    end
                end
            end
            if (ov16a && out_ready) begin
                n_checks++;
                if (q16a.size() == 0) begin
                    n_errors++; $display("FAIL rand16c4_spurious: got sum %h expected no output", sum16a);
                end else begin
                    exp = q16a.pop_front();
                    if ({z16a, of16a, co16a, 16'h0, sum16a} !== exp) begin
                        n_errors++; $display("FAIL rand16c4_result: got %h expected %h", {z16a, of16a, co16a, 16'h0, sum16a}, exp);
                    end
                end
            end
            if (ov16b && out_ready) begin
                n_checks++;
                if (q16b.size() == 0) begin
                    n_errors++; $display("FAIL rand16c16_spurious: got sum %h expected no output", sum16b);
                end else begin
                    exp = q16b.pop_front();
                    if ({z16b, of16b, co16b, 16'h0, sum16b} !== exp) begin
                        n_errors++; $display("FAIL rand16c16_result: got %h expected %h", {z16b, of16b, co16b, 16'h0, sum16b}, exp);
                    end
                end
            end
            if (in_valid && ir32)  begin q32.push_back(model(32, a, b, cin, sub));  acc32++;  end
            if (in_valid && ir16a) begin q16a.push_back(model(16, a, b, cin, sub)); acc16a++; end
            if (in_valid && ir16b) begin q16b.push_back(model(16, a, b, cin, sub)); acc16b++; end
            @(posedge clk);
            #1;
            cyc++;
        end
        n_checks++;
        if (drain < 20) begin n_errors++; $display("FAIL rand_timeout: got %0d cycles expected completion", cyc); end
        n_checks++;
        if (q32.size() + q16a.size() + q16b.size() != 0) begin
            n_errors++; $display("FAIL rand_lost_beats: got %0d/%0d/%0d pending expected 0/0/0",
                                 q32.size(), q16a.size(), q16b.size());
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        test_reset();
        test_flags();
        test_back_to_back();
        test_reset_flush();
        test_width16();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor. It is the next-generation datapath adder for the ALU.
- Splits a WIDTH-bit operation into STAGES = WIDTH/CHUNK ripple chunks. One chunk is resolved per clock, and the carry is registered between stages.
- Adds a valid/ready handshake with backpressure, a subtract mode, carry-in, and status flags (carry, signed overflow, zero).
- Sits between the operand/decode logic and the ALU result mux.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per pipeline stage. Must be at least 1. STAGES = WIDTH/CHUNK.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  0: A+B+cin; 1: A-B, computed as A+~B+1.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1. In sub mode, 1 means no borrow.
- overflow  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All stage valid bits clear; sum, cout, overflow, zero go to 0; out_valid=0.
  - in_ready = 1 in the first cycle after reset.
  - In-flight operations are discarded. No partial result ever appears.
- Pipeline enable:
  - adv = !out_valid || out_ready. in_ready = adv (combinational).
  - The whole pipeline shifts only when adv=1. When adv=0, every stage, including the output register, holds.
- Accept: a beat is taken when in_valid && in_ready. At stage 0:
  - b_eff = sub ? ~b : b.
  - carry0 = sub ? 1 : cin.
- Stage k (0..STAGES-1):
  - Adds chunk k of a and b_eff plus the registered carry from stage k-1 (carry0 for k=0).
  - Registers the CHUNK-bit partial sum, the carry out, and the remaining unconsumed operand chunks.
  - Already-computed lower sum chunks are carried forward unchanged.
- Latency: exactly STAGES cycles from an accepting edge to out_valid=1 at the final register, when adv stays 1. For 32/8 that is 4 cycles.
- Throughput: one result per cycle with no bubbles while out_ready=1.
- Bubbles: if in_valid=0 on an advancing cycle, stage 0 loads valid=0 and the bubble propagates. Operand data in a bubble stage is don't-care.
- Flags are registered with sum in the final stage:
  - cout = carry out of the MSB chunk.
  - overflow = carry into the MSB XOR carry out of the MSB, i.e. a[W-1]==b_eff[W-1] and sum[W-1]!=a[W-1].
  - zero = ~|sum.
- Backpressure: while out_valid=1 && out_ready=0:
  - sum and the flags are stable, and in_ready=0.
  - No beat is lost, duplicated or reordered.
- Same-cycle events:
  - out_ready=1 with out_valid=1 and in_valid=1: the output pops and the new beat is accepted in the same cycle.
- Widths: all arithmetic is modulo 2^WIDTH; sum is never extended.
- Degenerate case: CHUNK=WIDTH gives STAGES=1 and latency 1.

Test Plan:
- WIDTH=32/CHUNK=8, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 4 cycles later: sum=0x00000000, cout=1, overflow=0, zero=1.
- a=0x7FFFFFFF, b=0x00000001, sub=0 -> sum=0x80000000, cout=0, overflow=1, zero=0. Also a=0x00000003, b=0x00000004, cin=1 -> sum=0x00000008.
- sub=1, a=5, b=7 -> sum=0xFFFFFFFE, cout=0, overflow=0. Also sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, overflow=1, cout=1. cin is ignored in sub mode.
- Stream 8 back-to-back beats a=i, b=i*3 (i=0..7) with out_ready=1 for 5 cycles, then 0 for 3 cycles, then 1:
  - in_ready drops the same cycle out_ready drops.
  - Outputs are 0,4,8,...,28, in order, with no gaps or duplicates.
  - sum is held stable during the stall.
- Issue 3 beats, then assert rst_n=0 for one cycle -> out_valid stays 0 and none of the 3 results appears. The next beat a=1, b=1 yields sum=2 exactly 4 cycles after acceptance.
- WIDTH=16/CHUNK=4, a=0x0FFF, b=0x0001 -> sum=0x1000 after 4 cycles.
- WIDTH=16/CHUNK=16, a=0x0FFF, b=0x0001 -> sum=0x1000 after 1 cycle.
- Random run of 10k beats against a reference model, with random in_valid/out_ready, at WIDTH/CHUNK = 32/8, 16/4, 16/16.
